stream_arbiter_wrr: RTL and testbench

Weighted round-robin stream arbiter: merges N_INP valid/ready input streams onto one output stream, giving each input a programmable number of consecutive grants per turn. It keeps the AXI-style lock-in guarantee: once the output is valid, data and index stay fixed until the handshake. It adds a synchronous flush and exports the winning index. It sits wherever several requesters share one stream sink, for example interconnect ports or shared FPU/memory request paths.

---
 rtl/stream_arbiter_wrr_pkg.sv | 15 +
 rtl/stream_arbiter_wrr_search.sv | 43 ++++
 rtl/stream_arbiter_wrr.sv | 125 ++++++++++++
 tb/tb_stream_arbiter_wrr.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/stream_arbiter_wrr_pkg.sv
// Shared types and elaboration helpers for the weighted round-robin stream arbiter.
// The arbitration mode enum and the index-width derivation live here.
package stream_arbiter_wrr_pkg;

  typedef enum logic {
    ARB_WRR  = 1'b0,
    ARB_PRIO = 1'b1
  } arb_mode_e;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? unsigned'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/stream_arbiter_wrr_search.sv
// Rotating first-one search: the lowest set request at or after 'offset',
// wrapping modulo N_INP. Built as rotate -> trailing-zero count -> un-rotate.
module stream_arbiter_wrr_search #(
  parameter int unsigned N_INP = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_INP-1:0] req,
  input  logic [IDX_W-1:0] offset,
  output logic [IDX_W-1:0] idx
);

  logic [N_INP-1:0] rotated;
  logic [IDX_W-1:0] tz;
  logic [IDX_W:0]   src;
  logic [IDX_W:0]   sum;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    rotated = '0;
    src     = '0;
    for (int i = 0; i < int'(N_INP); i++) begin
      src = {1'b0, offset} + (IDX_W+1)'(i);
      if (src >= (IDX_W+1)'(N_INP)) src = src - (IDX_W+1)'(N_INP);
      rotated[i] = req[src[IDX_W-1:0]];
    end
  end

  // Scanning downward leaves the lowest set position in tz.
  always_comb begin
    tz = '0;
    for (int i = int'(N_INP) - 1; i >= 0; i--) begin
      if (rotated[i]) tz = IDX_W'(i);
    end
  end

  always_comb begin
    sum = {1'b0, tz} + {1'b0, offset};
    if (sum >= (IDX_W+1)'(N_INP)) sum = sum - (IDX_W+1)'(N_INP);
    idx = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/stream_arbiter_wrr.sv
// Weighted round-robin (or fixed-priority) valid/ready stream arbiter with
// AXI-style lock-in, synchronous flush and an exported winner index.
module stream_arbiter_wrr
  import stream_arbiter_wrr_pkg::*;
#(
  parameter type         DATA_T   = logic,
  parameter int unsigned N_INP    = 4,
  parameter int unsigned WEIGHT_W = 4,
  parameter              MODE     = "wrr",
  localparam int unsigned IDX_W   = idx_width(N_INP)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             flush_i,
  input  logic [N_INP-1:0][WEIGHT_W-1:0]   weight_i,
  input  DATA_T [N_INP-1:0]                inp_data_i,
  input  logic [N_INP-1:0]                 inp_valid_i,
  output logic [N_INP-1:0]                 inp_ready_o,
  output DATA_T                            oup_data_o,
  output logic                             oup_valid_o,
  input  logic                             oup_ready_i,
  output logic [IDX_W-1:0]                 oup_idx_o
);

  localparam bit IS_WRR  = (MODE == "wrr");
  localparam bit IS_PRIO = (MODE == "prio");
  localparam arb_mode_e ARB_MODE = IS_PRIO ? ARB_PRIO : ARB_WRR;

  if (N_INP < 2) begin : g_bad_n_inp
    $fatal(1, "stream_arbiter_wrr: N_INP must be at least 2");
  end
  if (!(IS_WRR || IS_PRIO)) begin : g_bad_mode
    $fatal(1, "stream_arbiter_wrr: MODE must be \"wrr\" or \"prio\"");
  end

  logic [IDX_W-1:0]    owner_q;
  logic [WEIGHT_W:0]   cnt_q;
  logic                lock_q;
  logic [IDX_W-1:0]    lock_idx_q;

  logic [IDX_W-1:0]    search_off;
  logic [IDX_W-1:0]    search_idx;
  logic [IDX_W-1:0]    winner;
  logic [WEIGHT_W-1:0] owner_weight;
  logic                turn_open;
  logic                retain;
  logic                keep_turn;
  logic                sel_valid;
  logic                hs;

  // The search starts just past the owner; priority mode always starts at 0.
  always_comb begin
    search_off = '0;
    if (ARB_MODE == ARB_WRR && owner_q != IDX_W'(N_INP - 1)) begin
      search_off = owner_q + IDX_W'(1);
    end
  end

  stream_arbiter_wrr_search #(
    .N_INP (N_INP),
    .IDX_W (IDX_W)
  ) u_search (
    .req    (inp_valid_i),
    .offset (search_off),
    .idx    (search_idx)
  );

  // cnt_q == 0 means no turn is in progress (reset/flush), so the first
  // decision always searches rather than retaining the default owner.
  assign owner_weight = weight_i[owner_q];
  assign turn_open    = (cnt_q != '0) && (cnt_q <= {1'b0, owner_weight});
  assign retain       = (ARB_MODE == ARB_WRR) && inp_valid_i[owner_q] && turn_open;
  assign keep_turn    = (winner == owner_q) && turn_open;

  always_comb begin
    winner      = lock_q ? lock_idx_q : (retain ? owner_q : search_idx);
    sel_valid   = lock_q ? inp_valid_i[lock_idx_q] : |inp_valid_i;
    oup_valid_o = sel_valid & ~flush_i;
    oup_data_o  = inp_data_i[winner];
    oup_idx_o   = oup_valid_o ? winner : '0;
    hs          = oup_valid_o & oup_ready_i;
    inp_ready_o = '0;
    inp_ready_o[winner] = hs;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q    <= IDX_W'(N_INP - 1);
      cnt_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (flush_i) begin
      owner_q    <= IDX_W'(N_INP - 1);
      cnt_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (hs) begin
      lock_q <= 1'b0;
      if (ARB_MODE == ARB_WRR) begin
        owner_q <= winner;
        cnt_q   <= keep_turn ? cnt_q + (WEIGHT_W+1)'(1) : (WEIGHT_W+1)'(1);
      end
    end else if (oup_valid_o) begin
      lock_q     <= 1'b1;
      lock_idx_q <= winner;
    end
  end

`ifndef SYNTHESIS
  a_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(inp_ready_o))
    else $error("inp_ready_o is not one-hot or zero");

  a_data_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (oup_valid_o && !oup_ready_i) |=> (flush_i || !oup_valid_o || $stable(oup_data_o)))
    else $error("oup_data_o changed while locked");

  a_lock_valid_drop: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (lock_q && !flush_i) |-> inp_valid_i[lock_idx_q])
    else $error("locked input dropped valid before handshake");
`endif

endmodule

// File: tb/tb_stream_arbiter_wrr.sv
// Randomised and directed bench for stream_arbiter_wrr: one "wrr" and one "prio"
// instance share stimulus and are each compared against a behavioural model.
module tb_stream_arbiter_wrr;

  localparam int N  = 4;
  localparam int WW = 4;
  typedef logic [7:0] data_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                     flush;
  logic [N-1:0][WW-1:0]     weight;
  data_t [N-1:0]            data;
  logic [N-1:0]             valid;
  logic                     ready;

  logic [1:0][N-1:0]        rdy_o;
  logic [1:0]               val_o;
  data_t [1:0]              dat_o;
  logic [1:0][1:0]          idx_o;

  stream_arbiter_wrr #(.DATA_T(data_t), .N_INP(N), .WEIGHT_W(WW), .MODE("wrr")) u_wrr (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .weight_i(weight),
    .inp_data_i(data), .inp_valid_i(valid), .inp_ready_o(rdy_o[0]),
    .oup_data_o(dat_o[0]), .oup_valid_o(val_o[0]), .oup_ready_i(ready),
    .oup_idx_o(idx_o[0])
  );

  stream_arbiter_wrr #(.DATA_T(data_t), .N_INP(N), .WEIGHT_W(WW), .MODE("prio")) u_prio (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .weight_i(weight),
    .inp_data_i(data), .inp_valid_i(valid), .inp_ready_o(rdy_o[1]),
    .oup_data_o(dat_o[1]), .oup_valid_o(val_o[1]), .oup_ready_i(ready),
    .oup_idx_o(idx_o[1])
  );

  // Model state per instance (0 = wrr, 1 = prio): whose turn it is, how many
  // grants that turn has used, and any pending stalled offer.
  int m_owner [2];
  int m_used [2];
  bit m_locked [2];
  int m_lock_idx [2];
  bit m_lock_ret [2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset(input int m);
    m_owner[m]    = N - 1;
    m_used[m]     = 0;
    m_locked[m]   = 1'b0;
    m_lock_idx[m] = 0;
    m_lock_ret[m] = 1'b0;
  endtask

  // Decide who is offered this cycle and whether it continues the current turn.
  task automatic eval(input int m, output bit ev, output int w, output bit ret);
    ev  = 1'b0;
    w   = 0;
    ret = 1'b0;
    if (flush) return;
    if (m_locked[m]) begin
      w   = m_lock_idx[m];
      ev  = valid[2'(w)];
      ret = m_lock_ret[m];
      return;
    end
    ev = |valid;
    if (!ev) return;
    if (m == 1) begin
      for (int i = N - 1; i >= 0; i--) if (valid[2'(i)]) w = i;
    end else if (valid[2'(m_owner[0])] && m_used[0] > 0 &&
                 m_used[0] <= int'(weight[2'(m_owner[0])])) begin
      w   = m_owner[0];
      ret = 1'b1;
    end else begin
      for (int k = N; k >= 1; k--) begin
        if (valid[2'((m_owner[0] + k) % N)]) w = (m_owner[0] + k) % N;
      end
    end
  endtask

  // Inputs are set at the falling edge; check 1 ns later, then advance models.
  task automatic step(input int exp_w, input int exp_p);
    bit ev [2];
    int w [2];
    bit ret [2];
    logic [N-1:0] er;
    #1;
    for (int m = 0; m < 2; m++) begin
      if (!rst_n) model_reset(m);
      eval(m, ev[m], w[m], ret[m]);
      er = '0;
      if (ev[m] && ready) er[2'(w[m])] = 1'b1;
      check($sformatf("valid[%0d]", m), 32'(val_o[m]), 32'(ev[m]));
      check($sformatf("idx[%0d]", m), 32'(idx_o[m]), ev[m] ? 32'(w[m]) : 32'd0);
      check($sformatf("ready[%0d]", m), 32'(rdy_o[m]), 32'(er));
      if (ev[m]) check($sformatf("data[%0d]", m), 32'(dat_o[m]), 32'(data[2'(w[m])]));
    end
    if (exp_w >= 0) check("wrr_grant", 32'(idx_o[0]), 32'(exp_w));
    if (exp_p >= 0) check("prio_grant", 32'(idx_o[1]), 32'(exp_p));
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (!rst_n || flush) begin
        model_reset(m);
      end else if (ev[m] && ready) begin
        m_locked[m] = 1'b0;
        if (m == 0) begin
          m_used[0]  = ret[0] ? m_used[0] + 1 : 1;
          m_owner[0] = w[0];
        end
      end else if (ev[m]) begin
        m_locked[m]   = 1'b1;
        m_lock_idx[m] = w[m];
        m_lock_ret[m] = ret[m];
      end
    end
    @(negedge clk);
  endtask

  int seq2 [7] = '{0, 0, 0, 1, 2, 2, 3};

  initial begin
    rst_n  = 1'b0;
    flush  = 1'b0;
    valid  = '0;
    ready  = 1'b0;
    weight = '0;
    for (int i = 0; i < N; i++) data[i] = 8'($urandom);
    model_reset(0);
    model_reset(1);

    // Reset state: everything idle.
    @(negedge clk);
    step(-1, -1);
    step(-1, -1);
    rst_n = 1'b1;

    // Plain round robin with all weights 0.
    valid = 4'b1111;
    ready = 1'b1;
    for (int i = 0; i < 8; i++) step(i % 4, 0);

    // Weights {2,0,1,0}: 0,0,0,1,2,2,3 repeating.
    weight[0] = 4'd2;
    weight[2] = 4'd1;
    for (int i = 0; i < 14; i++) step(seq2[i % 7], 0);

    // Stall on input 2 while input 0 rises; index and data stay on 2.
    weight = '0;
    valid  = 4'b0100;
    ready  = 1'b0;
    step(2, 2);
    valid = 4'b0101;
    step(2, 2);
    step(2, 2);
    ready = 1'b1;
    step(2, 2);
    step(0, 0);

    // Lone input 1 with weight 1: granted every cycle.
    valid     = 4'b0010;
    weight[1] = 4'd1;
    for (int i = 0; i < 5; i++) step(1, 1);

    // Flush while locked on input 3, then the grant restarts at 0.
    weight = '0;
    valid  = 4'b1000;
    ready  = 1'b0;
    step(3, 3);
    flush = 1'b1;
    valid = 4'b1111;
    step(-1, -1);
    flush = 1'b0;
    ready = 1'b1;
    step(0, 0);

    // Priority mode: input 1 wins until it drops, then input 3.
    valid = 4'b1010;
    for (int i = 0; i < 4; i++) step(-1, 1);
    valid = 4'b1000;
    step(-1, 3);
    step(-1, 3);
    ready = 1'b0;
    step(3, 3);
    // Asynchronous reset mid-lock releases the lock at once.
    rst_n = 1'b0;
    valid = 4'b1010;
    step(1, 1);
    rst_n = 1'b1;
    ready = 1'b1;
    step(1, 1);

    // Random traffic with protocol-respecting holds on stalled inputs.
    for (int c = 0; c < 600; c++) begin
      flush = ($urandom_range(0, 39) == 0);
      if (!m_locked[0] && !m_locked[1] && $urandom_range(0, 15) == 0) begin
        for (int i = 0; i < N; i++)
          weight[i] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
      end
      valid = ($urandom_range(0, 4) == 0) ? 4'b1111 : 4'($urandom);
      for (int i = 0; i < N; i++) begin
        if (!((m_locked[0] && m_lock_idx[0] == i) || (m_locked[1] && m_lock_idx[1] == i)))
          data[i] = 8'($urandom);
      end
      for (int m = 0; m < 2; m++) if (m_locked[m]) valid[2'(m_lock_idx[m])] = 1'b1;
      ready = ($urandom_range(0, 9) < 7);
      step(-1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
